// File: rtl/fanfare_player.sv
// Plays the 6-note "charge" fanfare as a differential square wave on piezo/piezo_n.
// Optional macro FANFARE_FAST_SIM_EN shortens the duration unit 16x for full-chip sims.
module fanfare_player #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DUR_UNIT_LOG2 = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx,
  output logic       piezo,
  output logic       piezo_n
);

`ifdef FANFARE_FAST_SIM_EN
  localparam int UNIT_LOG2 = DUR_UNIT_LOG2 - 4;
`else
  localparam int UNIT_LOG2 = DUR_UNIT_LOG2;
`endif
  localparam int UNIT = 2 ** UNIT_LOG2;

  localparam int P_G6 = CLK_FREQ_HZ / 1568;
  localparam int P_C7 = CLK_FREQ_HZ / 2093;
  localparam int P_E7 = CLK_FREQ_HZ / 2637;
  localparam int P_G7 = CLK_FREQ_HZ / 3136;

  // G6 is the lowest note, so it has the longest period.
  localparam int TW = $clog2(P_G6);
  localparam int DW = $clog2(8 * (2 ** DUR_UNIT_LOG2));

  typedef enum logic [2:0] {
    IDLE = 3'd0, G6 = 3'd1, C7 = 3'd2, E7_1 = 3'd3,
    G7_1 = 3'd4, E7_2 = 3'd5, G7_2 = 3'd6
  } state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  tone_cnt, tone_nx;
  logic [DW-1:0]  dur_cnt, dur_nx;
  logic           clr;
  logic           tone_hi;

  function automatic logic [TW-1:0] per_m1(input state_t s);
    case (s)
      G6:          per_m1 = TW'(P_G6 - 1);
      C7:          per_m1 = TW'(P_C7 - 1);
      E7_1, E7_2:  per_m1 = TW'(P_E7 - 1);
      G7_1, G7_2:  per_m1 = TW'(P_G7 - 1);
      default:     per_m1 = '0;
    endcase
  endfunction

  function automatic logic [TW-1:0] half(input state_t s);
    case (s)
      G6:          half = TW'(P_G6 / 2);
      C7:          half = TW'(P_C7 / 2);
      E7_1, E7_2:  half = TW'(P_E7 / 2);
      G7_1, G7_2:  half = TW'(P_G7 / 2);
      default:     half = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] dur_lim(input state_t s);
    case (s)
      G6, C7, E7_1: dur_lim = DW'(2 * UNIT - 1);
      G7_1:         dur_lim = DW'(3 * UNIT - 1);
      E7_2:         dur_lim = DW'(UNIT - 1);
      G7_2:         dur_lim = DW'(8 * UNIT - 1);
      default:      dur_lim = '0;
    endcase
  endfunction

  function automatic state_t next_note(input state_t s);
    case (s)
      G6:      next_note = C7;
      C7:      next_note = E7_1;
      E7_1:    next_note = G7_1;
      G7_1:    next_note = E7_2;
      E7_2:    next_note = G7_2;
      default: next_note = IDLE;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    tone_nx  = tone_cnt;
    dur_nx   = dur_cnt;
    clr      = (state != IDLE) && (dur_cnt == dur_lim(state));
    if (state == IDLE) begin
      if (go) begin
        state_nx = G6;
        tone_nx  = '0;
        dur_nx   = '0;
      end
    end else if (clr) begin
      state_nx = next_note(state);
      tone_nx  = '0;
      dur_nx   = '0;
    end else begin
      dur_nx  = dur_cnt + 1'b1;
      tone_nx = (tone_cnt == per_m1(state)) ? '0 : tone_cnt + 1'b1;
    end
    // Outputs are registered from next-state values so a note starts with piezo=1.
    tone_hi = tone_nx < half(state_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= 3'd0;
      piezo    <= 1'b0;
      piezo_n  <= 1'b0;
    end else begin
      state    <= state_nx;
      tone_cnt <= tone_nx;
      dur_cnt  <= dur_nx;
      busy     <= (state_nx != IDLE);
      done     <= (state == G7_2) && clr;
      note_idx <= state_nx;
      piezo    <= (state_nx != IDLE) && tone_hi;
      piezo_n  <= (state_nx != IDLE) && !tone_hi;
    end
  end

endmodule

// File: tb/tb_fanfare_player.sv
// Directed bench for fanfare_player using a scaled clock frequency and duration unit
// so complete tunes fit in a short run.
module tb_fanfare_player;

  localparam int CLK_HZ = 50_000;
  localparam int DUL    = 9;
`ifdef FANFARE_FAST_SIM_EN
  localparam int UNIT = 1 << (DUL - 4);
`else
  localparam int UNIT = 1 << DUL;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       busy, done, piezo, piezo_n;
  logic [2:0] note_idx;

  fanfare_player #(.CLK_FREQ_HZ(CLK_HZ), .DUR_UNIT_LOG2(DUL)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .note_idx(note_idx), .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [2:0] idx;
    int         units;
    int         period;
    int         high;
  } note_t;
  note_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_note_idx"}, 32'(note_idx), 32'd0);
    chk({tag, "_piezo"}, 32'(piezo), 32'd0);
    chk({tag, "_piezo_n"}, 32'(piezo_n), 32'd0);
  endtask

  // Plays one tune from a go pulse; repulse drives go during E7_1 and on the final edge.
  task automatic run_tune(input string tag, input bit repulse);
    int   n, werr, fall_at, rise_at, dur;
    logic exp_p;
    for (int k = 1; k <= 6; k++) exp_q.push_back(3'(k));
    exp_q.push_back(3'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dur = tbl[i].units * UNIT;
      n = 0; werr = 0; fall_at = -1; rise_at = -1;
      chk($sformatf("%s_seq%0d", tag, i + 1), 32'(note_idx), 32'(exp_q.pop_front()));
      while (note_idx === tbl[i].idx && n < dur + 8) begin
        exp_p = (n % tbl[i].period) < tbl[i].high;
        if (piezo !== exp_p || piezo_n !== ~exp_p || busy !== 1'b1 || done !== 1'b0) werr++;
        if (n > 0 && fall_at < 0 && piezo === 1'b0) fall_at = n;
        if (fall_at >= 0 && rise_at < 0 && piezo === 1'b1) rise_at = n;
        if (repulse && ((i == 2 && n == 7) || (i == 5 && n == dur - 1))) go = 1'b1;
        tick();
        go = 1'b0;
        n++;
      end
      chk($sformatf("%s_n%0d_len", tag, i + 1), 32'(n), 32'(dur));
      chk($sformatf("%s_n%0d_wave_errs", tag, i + 1), 32'(werr), 32'd0);
      chk($sformatf("%s_n%0d_high", tag, i + 1), 32'(fall_at), 32'(tbl[i].high));
      chk($sformatf("%s_n%0d_period", tag, i + 1), 32'(rise_at), 32'(tbl[i].period));
    end
    chk({tag, "_seq_end"}, 32'(note_idx), 32'(exp_q.pop_front()));
    check_idle({tag, "_done_cyc"}, 1'b1);
    tick();
    check_idle({tag, "_after"}, 1'b0);
    repeat (5) tick();
    check_idle({tag, "_no_restart"}, 1'b0);
  endtask

  initial begin
    int wait_n;
    // Periods are CLK_HZ/f truncated: 50000/1568=31, /2093=23, /2637=18, /3136=15.
    tbl[0] = '{3'd1, 2, 31, 15};
    tbl[1] = '{3'd2, 2, 23, 11};
    tbl[2] = '{3'd3, 2, 18, 9};
    tbl[3] = '{3'd4, 3, 15, 7};
    tbl[4] = '{3'd5, 1, 18, 9};
    tbl[5] = '{3'd6, 8, 15, 7};

    rst_n = 1'b0;
    go    = 1'b0;
    repeat (2) tick();
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_idle("idle", 1'b0);

    run_tune("tune", 1'b0);
    run_tune("repulse", 1'b1);

    go = 1'b1;
    tick();
    go = 1'b0;
    wait_n = 0;
    while (note_idx !== 3'd3 && wait_n < 8 * UNIT) begin
      tick();
      wait_n++;
    end
    chk("reach_e7_1", 32'(note_idx), 32'd3);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("abort", 1'b0);
    repeat (3) tick();
    check_idle("abort_idle", 1'b0);
    run_tune("after_abort", 1'b0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
